rename_map_ckpt: RTL and testbench
==================================

# rename_map_ckpt

Parametrised rename map with branch checkpoints; successor to the single-level RAT/RRAT pair. It translates up to WAYS architectural sources and destinations per cycle into PRF tags and keeps the committed (retirement) map. It also holds up to CKPTS speculative map snapshots, so a branch mispredict restores the map in one cycle without waiting for retirement. It sits between decode and dispatch, alongside the free list and the valid list.

## Interface
- WAYS, 4, rename/retire bundle width
- ARCH_REGS, 32, architectural registers (power of two); AW = $clog2(ARCH_REGS)
- PRF, 64, physical registers; PW = $clog2(PRF)
- CKPTS, 4, snapshot slots (power of two); CW = $clog2(CKPTS)

- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- except  in  1  full flush to committed map
- rda_idx, rdb_idx  in  WAYS×AW  source queries
- dest_idx  in  WAYS×AW  destinations to rename
- dest_valid  in  WAYS  rename request per way
- new_prf  in  WAYS×PW  free-list tags, one per way
- ckpt_req  in  WAYS  branch in way i; at most one bit set
- rename_stall  out  1  bundle rejected this cycle (combinational)
- ckpt_id  out  CW  slot assigned to the requesting branch
- rda_prf, rdb_prf  out  WAYS×PW  source tags, forwarded within bundle
- old_dest_prf  out  WAYS×PW  prior mapping of dest_idx[i], forwarded
- resolve_valid, resolve_mispredict  in  1 each  branch outcome
- resolve_id  in  CW  slot being resolved
- retire_arch  in  WAYS×AW; retire_prf  in  WAYS×PW; retire_valid  in  WAYS  commits
- retire_old_prf  out  WAYS×PW  committed tag displaced (to free list), forwarded
- ckpt_full  out  1  no free slot

## Operation
- State: spec map M[ARCH_REGS], committed map C[ARCH_REGS], CKPTS snapshots S[k], done[k], circular head/tail pointers (CW+1 bits), count.
- Source lookup, way i: M with renames of ways 0..i-1 applied; the highest such way wins. old_dest_prf[i] is built the same way.
- Rename: on an accepted bundle, M ← M with all valid ways applied in way order; the highest way wins on a duplicate dest.
- Checkpoint: if ckpt_req[i], S[tail] ← M with ways 0..i applied; ckpt_id = tail[CW-1:0]; tail+1.
- Stall: rename_stall = |ckpt_req & ckpt_full. A stalled bundle changes no M, S or tail; upstream holds it.
- Correct resolve: done[resolve_id] ← 1. head advances by one per cycle while done[head] is set, clearing it.
- Mispredict: M ← S[resolve_id]; tail ← resolve_id+1 (same wrap bit as the slot); done cleared for all discarded younger slots. The rename bundle in the same cycle is ignored, and rename_stall is forced high.
- Retire: C[retire_arch[i]] ← retire_prf[i] in way order. retire_old_prf[i] comes from C with retiring ways 0..i-1 forwarded.
- except: M ← C-next (retires of that cycle applied); head = tail = 0; all done cleared. Renames and resolves that cycle are dropped.
- Priority: reset > except > mispredict > rename; retire always applies except under reset.
- Resolve on an unallocated slot: undefined. The bench must not drive it.

## Timing
- All lookups and old-tag outputs are combinational from current state plus the same-cycle bundle; updates take effect at the next posedge.
- Restored map is visible to lookups 1 cycle after resolve_mispredict.
- A checkpoint freed by correct resolve is reusable 1 cycle after head passes it; ckpt_full = (count == CKPTS).
- Reset values: M[r] = C[r] = r for r < ARCH_REGS; head = tail = 0; done = 0; ckpt_full = 0; rename_stall = 0 with ckpt_req = 0; ckpt_id = 0.
- Wrap: pointers carry an extra wrap bit. Full means same index with opposite wrap bit; empty means pointers equal.

## Configuration
- RENAME_ZERO_REG_EN defined: arch reg 0 is never renamed. dest_valid for dest_idx = 0 is ignored for M, S and C. Lookups of reg 0 return PRF 0. old_dest_prf/retire_old_prf report PRF 0, and the free list must not free that tag.
- RENAME_ZERO_REG_EN undefined: reg 0 is renamed like any other register.

## Test plan
- Reset, then query rda_idx = 5 on all ways → rda_prf = 5; ckpt_full = 0; ckpt_id = 0.
- Way0 dest 3 → PRF 40, way2 dest 3 → PRF 41, way3 rda 3 → rda_prf[3] = 41, old_dest_prf[2] = 40; next cycle lookup 3 → 41.
- Branch in way1 (way0 r7 → 50, way2 r7 → 51) → ckpt_id = 0. Later mispredict id 0 → next-cycle lookup r7 = 50.
- Fill 4 checkpoints → ckpt_full = 1. Fifth ckpt_req → rename_stall = 1 and M unchanged. Correct-resolve id 0 → after head advance, request accepted with ckpt_id = 0 (wrap).
- Slots 0–2 live, mispredict id 1 → slot 2 discarded, tail = 2, count = 2. A same-cycle rename of r9 is dropped.
- except with retire r4 → 60 in the same cycle → next cycle lookup r4 = 60, all other regs = C, ckpt_full = 0. With RENAME_ZERO_REG_EN, rename dest 0 → lookup 0 stays 0.

Source files
------------

// File: rtl/rename_map_ckpt_if.sv
// Rename map bundle: decode-side queries, renames, resolves and retires.
// The master drives the requests; the slave returns tags and status.
interface rename_map_ckpt_if #(
  parameter int WAYS      = 4,
  parameter int ARCH_REGS = 32,
  parameter int PRF       = 64,
  parameter int CKPTS     = 4
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PRF);
  localparam int CW = $clog2(CKPTS);

  logic                     except;
  logic [WAYS-1:0][AW-1:0]  rda_idx;
  logic [WAYS-1:0][AW-1:0]  rdb_idx;
  logic [WAYS-1:0][AW-1:0]  dest_idx;
  logic [WAYS-1:0]          dest_valid;
  logic [WAYS-1:0][PW-1:0]  new_prf;
  logic [WAYS-1:0]          ckpt_req;
  logic                     rename_stall;
  logic [CW-1:0]            ckpt_id;
  logic [WAYS-1:0][PW-1:0]  rda_prf;
  logic [WAYS-1:0][PW-1:0]  rdb_prf;
  logic [WAYS-1:0][PW-1:0]  old_dest_prf;
  logic                     resolve_valid;
  logic                     resolve_mispredict;
  logic [CW-1:0]            resolve_id;
  logic [WAYS-1:0][AW-1:0]  retire_arch;
  logic [WAYS-1:0][PW-1:0]  retire_prf;
  logic [WAYS-1:0]          retire_valid;
  logic [WAYS-1:0][PW-1:0]  retire_old_prf;
  logic                     ckpt_full;

  modport master (
    output except, rda_idx, rdb_idx, dest_idx, dest_valid,
    output new_prf, ckpt_req, resolve_valid, resolve_mispredict,
    output resolve_id, retire_arch, retire_prf, retire_valid,
    input  rename_stall, ckpt_id, rda_prf, rdb_prf,
    input  old_dest_prf, retire_old_prf, ckpt_full
  );

  modport slave (
    input  except, rda_idx, rdb_idx, dest_idx, dest_valid,
    input  new_prf, ckpt_req, resolve_valid, resolve_mispredict,
    input  resolve_id, retire_arch, retire_prf, retire_valid,
    output rename_stall, ckpt_id, rda_prf, rdb_prf,
    output old_dest_prf, retire_old_prf, ckpt_full
  );
endinterface

// File: rtl/rename_map_ckpt.sv
// Speculative + committed rename map with CKPTS branch snapshots.
// Define RENAME_ZERO_REG_EN to pin arch reg 0 to PRF 0.
module rename_map_ckpt #(
  parameter int WAYS      = 4,
  parameter int ARCH_REGS = 32,
  parameter int PRF       = 64,
  parameter int CKPTS     = 4
) (
  input logic              clock,
  input logic              reset,
  rename_map_ckpt_if.slave io
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PRF);
  localparam int CW = $clog2(CKPTS);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(CKPTS);

`ifdef RENAME_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  typedef logic [PW-1:0] tag_t;
  typedef logic [CW:0]   ptr_t;

  tag_t m_q [ARCH_REGS];
  tag_t m_d [ARCH_REGS];
  tag_t c_q [ARCH_REGS];
  tag_t c_d [ARCH_REGS];
  tag_t s_q [CKPTS][ARCH_REGS];
  tag_t s_d [CKPTS][ARCH_REGS];
  logic [CKPTS-1:0] done_q, done_d;
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;

  tag_t spec_nxt [ARCH_REGS];
  tag_t cmt_nxt  [ARCH_REGS];
  tag_t ck_map   [ARCH_REGS];
  logic has_ck;

  ptr_t cnt;
  ptr_t rs_ptr;
  logic [CW-1:0] rs_off;
  logic [CW-1:0] k_off;
  logic mispred;
  logic full;
  logic ck_stall;
  logic accept;

  assign cnt      = tail_q - head_q;
  assign full     = (cnt == FULL_CNT);
  assign mispred  = io.resolve_valid & io.resolve_mispredict;
  assign ck_stall = (|io.ckpt_req) & full;
  assign accept   = ~io.except & ~mispred & ~ck_stall;

  assign io.ckpt_full    = full;
  assign io.ckpt_id      = tail_q[CW-1:0];
  assign io.rename_stall = ck_stall | mispred;

  // Walk the bundle way by way so each way sees older ways' writes.
  always_comb begin
    tag_t sm [ARCH_REGS];
    tag_t cm [ARCH_REGS];
    logic dv;
    logic rv;
    sm = m_q;
    cm = c_q;
    ck_map = m_q;
    has_ck = 1'b0;
    io.rda_prf = '0;
    io.rdb_prf = '0;
    io.old_dest_prf = '0;
    io.retire_old_prf = '0;
    for (int i = 0; i < WAYS; i++) begin
      dv = io.dest_valid[i] & ~(ZR & (io.dest_idx[i] == '0));
      rv = io.retire_valid[i] & ~(ZR & (io.retire_arch[i] == '0));
      if (!(ZR && io.rda_idx[i] == '0))
        io.rda_prf[i] = sm[io.rda_idx[i]];
      if (!(ZR && io.rdb_idx[i] == '0))
        io.rdb_prf[i] = sm[io.rdb_idx[i]];
      if (!(ZR && io.dest_idx[i] == '0))
        io.old_dest_prf[i] = sm[io.dest_idx[i]];
      if (!(ZR && io.retire_arch[i] == '0))
        io.retire_old_prf[i] = cm[io.retire_arch[i]];
      if (dv)
        sm[io.dest_idx[i]] = io.new_prf[i];
      if (rv)
        cm[io.retire_arch[i]] = io.retire_prf[i];
      if (io.ckpt_req[i]) begin
        ck_map = sm;
        has_ck = 1'b1;
      end
    end
    spec_nxt = sm;
    cmt_nxt = cm;
  end

  // Pointer of the resolving slot, rebuilt from head so it carries a wrap bit.
  assign rs_off = io.resolve_id - head_q[CW-1:0];
  assign rs_ptr = head_q + ptr_t'(rs_off);

  always_comb begin
    m_d = m_q;
    c_d = cmt_nxt;
    s_d = s_q;
    done_d = done_q;
    head_d = head_q;
    tail_d = tail_q;
    k_off = '0;
    if (done_q[head_q[CW-1:0]] && cnt != '0) begin
      done_d[head_q[CW-1:0]] = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (io.except) begin
      m_d = cmt_nxt;
      head_d = '0;
      tail_d = '0;
      done_d = '0;
    end else if (mispred) begin
      m_d = s_q[io.resolve_id];
      tail_d = rs_ptr + 1'b1;
      for (int k = 0; k < CKPTS; k++) begin
        k_off = CW'(k) - head_q[CW-1:0];
        if (k_off > rs_off && {1'b0, k_off} < cnt)
          done_d[k] = 1'b0;
      end
    end else begin
      if (io.resolve_valid)
        done_d[io.resolve_id] = 1'b1;
      if (accept) begin
        m_d = spec_nxt;
        if (has_ck) begin
          s_d[tail_q[CW-1:0]] = ck_map;
          tail_d = tail_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ARCH_REGS; r++) begin
        m_q[r] <= tag_t'(r);
        c_q[r] <= tag_t'(r);
      end
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      m_q <= m_d;
      c_q <= c_d;
      s_q <= s_d;
      done_q <= done_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: tb/tb_rename_map_ckpt.sv
// Directed scoreboard bench for rename_map_ckpt.
// Driver queues expectations per cycle; a negedge monitor checks them.
module tb_rename_map_ckpt;
  localparam int RDA = 0;
  localparam int RDB = 1;
  localparam int OLD = 2;
  localparam int RET = 3;
  localparam int STL = 4;
  localparam int CID = 5;
  localparam int FUL = 6;

`ifdef RENAME_ZERO_REG_EN
  localparam int ZEXP = 0;
`else
  localparam int ZEXP = 44;
`endif

  typedef struct {
    int    cyc;
    int    sel;
    int    way;
    int    val;
    string nm;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];

  rename_map_ckpt_if rif ();

  rename_map_ckpt dut (
    .clock (clock),
    .reset (reset),
    .io    (rif)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int act(int sel, int way);
    case (sel)
      RDA:     return int'(rif.rda_prf[way]);
      RDB:     return int'(rif.rdb_prf[way]);
      OLD:     return int'(rif.old_dest_prf[way]);
      RET:     return int'(rif.retire_old_prf[way]);
      STL:     return int'(rif.rename_stall);
      CID:     return int'(rif.ckpt_id);
      FUL:     return int'(rif.ckpt_full);
      default: return -1;
    endcase
  endfunction

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int a;
      e = sb.pop_front();
      n_cmp++;
      a = act(e.sel, e.way);
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s[%0d]: stale check from cycle %0d", e.nm, e.way, e.cyc);
      end else if (a != e.val) begin
        n_bad++;
        $display("FAIL %s[%0d]: got %0d expected %0d", e.nm, e.way, a, e.val);
      end
    end
  end

  task automatic clr();
    rif.except = 1'b0;
    rif.rda_idx = '0;
    rif.rdb_idx = '0;
    rif.dest_idx = '0;
    rif.dest_valid = '0;
    rif.new_prf = '0;
    rif.ckpt_req = '0;
    rif.resolve_valid = 1'b0;
    rif.resolve_mispredict = 1'b0;
    rif.resolve_id = '0;
    rif.retire_arch = '0;
    rif.retire_prf = '0;
    rif.retire_valid = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clr();
  endtask

  task automatic ex(int sel, int way, int val, string nm);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.way = way;
    e.val = val;
    e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int w = 0; w < 4; w++) begin
      rif.rda_idx[w] = 5'd5;
      ex(RDA, w, 5, "rst_rda");
    end
    ex(FUL, 0, 0, "rst_full");
    ex(CID, 0, 0, "rst_cid");
    ex(STL, 0, 0, "rst_stall");

    tick();
    rif.dest_idx[0] = 5'd3; rif.new_prf[0] = 6'd40;
    rif.dest_idx[2] = 5'd3; rif.new_prf[2] = 6'd41;
    rif.dest_valid = 4'b0101;
    for (int w = 0; w < 4; w++) rif.rda_idx[w] = 5'd3;
    ex(RDA, 0, 3, "fwd_rda"); ex(RDA, 1, 40, "fwd_rda");
    ex(RDA, 2, 40, "fwd_rda"); ex(RDA, 3, 41, "fwd_rda");
    ex(OLD, 0, 3, "fwd_old"); ex(OLD, 2, 40, "fwd_old");

    tick();
    rif.rda_idx[0] = 5'd3;
    ex(RDA, 0, 41, "ren_upd");
    rif.dest_idx[0] = 5'd7; rif.new_prf[0] = 6'd50;
    rif.dest_idx[2] = 5'd7; rif.new_prf[2] = 6'd51;
    rif.dest_valid = 4'b0101;
    rif.ckpt_req = 4'b0010;
    rif.rda_idx[3] = 5'd7; rif.rdb_idx[2] = 5'd7;
    ex(RDA, 3, 51, "br_rda"); ex(RDB, 2, 50, "br_rdb");
    ex(CID, 0, 0, "br_cid"); ex(STL, 0, 0, "br_stall");

    tick();
    rif.rda_idx[0] = 5'd7;
    ex(RDA, 0, 51, "pre_mp");
    rif.resolve_valid = 1'b1; rif.resolve_mispredict = 1'b1;
    rif.resolve_id = 2'd0;
    ex(STL, 0, 1, "mp_stall"); ex(FUL, 0, 0, "mp_full");

    tick();
    rif.rda_idx[0] = 5'd7; rif.rda_idx[1] = 5'd3;
    ex(RDA, 0, 50, "mp_rest"); ex(RDA, 1, 41, "mp_rest");
    rif.resolve_valid = 1'b1; rif.resolve_id = 2'd0;

    tick();
    for (int n = 0; n < 4; n++) begin
      tick();
      rif.ckpt_req = 4'b0001;
      ex(CID, 0, (n + 1) % 4, "fill_cid");
      ex(FUL, 0, 0, "fill_full");
      ex(STL, 0, 0, "fill_stall");
    end

    tick();
    rif.ckpt_req = 4'b0001;
    rif.dest_idx[0] = 5'd9; rif.new_prf[0] = 6'd60; rif.dest_valid = 4'b0001;
    rif.resolve_valid = 1'b1; rif.resolve_id = 2'd1;
    ex(FUL, 0, 1, "full_full"); ex(STL, 0, 1, "full_stall");
    ex(CID, 0, 1, "full_cid");

    tick();
    rif.rda_idx[0] = 5'd9;
    ex(RDA, 0, 9, "stall_nomap"); ex(FUL, 0, 1, "hd_full");

    tick();
    rif.ckpt_req = 4'b0001;
    ex(FUL, 0, 0, "wrap_full"); ex(STL, 0, 0, "wrap_stall");
    ex(CID, 0, 1, "wrap_cid");

    tick();
    rif.except = 1'b1;
    rif.retire_arch[0] = 5'd4; rif.retire_prf[0] = 6'd60;
    rif.retire_arch[1] = 5'd6; rif.retire_prf[1] = 6'd61;
    rif.retire_arch[2] = 5'd4;
    rif.retire_valid = 4'b0011;
    rif.dest_idx[0] = 5'd9; rif.new_prf[0] = 6'd33; rif.dest_valid = 4'b0001;
    ex(RET, 0, 4, "ret_old"); ex(RET, 1, 6, "ret_old");
    ex(RET, 2, 60, "ret_fwd"); ex(FUL, 0, 1, "exc_full");

    tick();
    rif.rda_idx[0] = 5'd4; rif.rda_idx[1] = 5'd3;
    rif.rda_idx[2] = 5'd7; rif.rda_idx[3] = 5'd9;
    rif.rdb_idx[0] = 5'd6; rif.retire_arch[0] = 5'd4;
    ex(RDA, 0, 60, "exc_map"); ex(RDA, 1, 3, "exc_map");
    ex(RDA, 2, 7, "exc_map"); ex(RDA, 3, 9, "exc_map");
    ex(RDB, 0, 61, "exc_map"); ex(RET, 0, 60, "exc_cmt");
    ex(FUL, 0, 0, "exc_full0"); ex(CID, 0, 0, "exc_cid");
    rif.ckpt_req = 4'b0001;

    tick();
    rif.ckpt_req = 4'b0001;
    ex(CID, 0, 1, "live_cid");

    tick();
    rif.ckpt_req = 4'b0001;
    ex(CID, 0, 2, "live_cid");

    tick();
    rif.resolve_valid = 1'b1; rif.resolve_mispredict = 1'b1;
    rif.resolve_id = 2'd1;
    rif.dest_idx[0] = 5'd9; rif.new_prf[0] = 6'd33; rif.dest_valid = 4'b0001;
    rif.rda_idx[0] = 5'd9;
    ex(STL, 0, 1, "mp1_stall"); ex(RDA, 0, 9, "mp1_pre");

    tick();
    rif.rda_idx[0] = 5'd9; rif.rdb_idx[0] = 5'd4;
    ex(RDA, 0, 9, "mp1_drop"); ex(RDB, 0, 60, "mp1_rest");
    ex(CID, 0, 2, "mp1_tail"); ex(FUL, 0, 0, "mp1_full");
    rif.ckpt_req = 4'b0001;

    tick();
    rif.ckpt_req = 4'b0001;
    ex(CID, 0, 3, "cnt_cid"); ex(FUL, 0, 0, "cnt_full");
    ex(STL, 0, 0, "cnt_stall");

    tick();
    rif.ckpt_req = 4'b0001;
    ex(FUL, 0, 1, "cnt_full4"); ex(STL, 0, 1, "cnt_stall4");
    ex(CID, 0, 0, "cnt_cid4");

    tick();
    rif.dest_idx[0] = 5'd0; rif.new_prf[0] = 6'd44; rif.dest_valid = 4'b0001;
    ex(STL, 0, 0, "z_stall");

    tick();
    rif.rda_idx[0] = 5'd0; rif.dest_idx[0] = 5'd0;
    ex(RDA, 0, ZEXP, "z_rda"); ex(OLD, 0, ZEXP, "z_old");

    tick();
    tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s[%0d]: never checked", e.nm, e.way);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
